// File: rtl/elevator_scan_ctrl.sv
// elevator_scan_ctrl: N-floor SCAN elevator controller with latched calls and a BCD maintenance lockout
module elevator_scan_ctrl #(
    parameter int          FLOORS        = 8,
    parameter int          FLOOR_W       = 3,
    parameter int          TRAVEL_CYCLES = 4,
    parameter int          DOOR_CYCLES   = 3,
    parameter logic [3:0]  MAINT_CODE    = 4'b1011,
    parameter logic [3:0]  RESUME_CODE   = 4'b1101
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic [3:0]         BCD_management,
    input  logic [FLOORS-1:0]  interior_movement,
    input  logic [FLOORS-1:0]  exterior_up,
    input  logic [FLOORS-1:0]  exterior_down,
    output logic [1:0]         engine,
    output logic [FLOORS-1:0]  doors,
    output logic [FLOOR_W-1:0] floor,
    output logic               dir_up,
    output logic               maint,
    output logic [FLOORS-1:0]  pending
);
    typedef enum logic [1:0] {S_IDLE, S_MOVE, S_DOOR, S_MAINT} state_t;

    localparam logic [FLOORS-1:0] ONE       = {{(FLOORS-1){1'b0}}, 1'b1};
    localparam logic [FLOORS-1:0] UP_MASK   = {1'b0, {(FLOORS-1){1'b1}}};
    localparam logic [FLOORS-1:0] DOWN_MASK = {{(FLOORS-1){1'b1}}, 1'b0};

    state_t             r_state, w_state_nx;
    logic [FLOOR_W-1:0] r_floor, w_floor_nx, w_nf;
    logic               r_dir, w_dir_nx;
    logic [15:0]        r_tcnt, w_tcnt_nx, r_dcnt, w_dcnt_nx;
    logic [FLOORS-1:0]  r_car, r_up, r_dn, w_car_nx, w_up_nx, w_dn_nx;
    logic [FLOORS-1:0]  w_up_in, w_dn_in, w_pend, w_oh, w_block;
    logic [FLOORS-1:0]  w_clr_car, w_clr_up, w_clr_dn;
    logic [1:0]         r_engine;
    logic [FLOORS-1:0]  r_doors;
    logic               r_maint_req, w_maint_req, w_maint_req_nx;
    logic               w_here, w_ahead, w_behind, w_arr_stop, w_arr_ahead, w_hit;
    logic               w_open, w_rev, w_wipe, w_resume;

    function automatic logic calls_ahead(input logic [FLOORS-1:0] p, input logic [FLOOR_W-1:0] f,
                                         input logic up);
        calls_ahead = 1'b0;
        for (int i = 0; i < FLOORS; i++)
            if (p[i] && (up ? (i > int'(f)) : (i < int'(f)))) calls_ahead = 1'b1;
    endfunction

    // A floor is served when it has a car call, a hall call in the travel direction,
    // or an opposite hall call and nothing further ahead (the car turns around here).
    function automatic logic serve(input logic [FLOORS-1:0] car, input logic [FLOORS-1:0] up,
                                   input logic [FLOORS-1:0] dn, input logic [FLOOR_W-1:0] f,
                                   input logic d);
        serve = car[f] | (d ? up[f] : dn[f]) | ((d ? dn[f] : up[f]) & ~calls_ahead(car | up | dn, f, d));
    endfunction

    assign w_up_in     = exterior_up & UP_MASK;
    assign w_dn_in     = exterior_down & DOWN_MASK;
    assign w_pend      = r_car | r_up | r_dn;
    assign w_nf        = r_dir ? r_floor + 1'b1 : r_floor - 1'b1;
    assign w_here      = serve(r_car, r_up, r_dn, r_floor, r_dir);
    assign w_ahead     = calls_ahead(w_pend, r_floor, r_dir);
    assign w_behind    = calls_ahead(w_pend, r_floor, ~r_dir);
    assign w_arr_stop  = serve(r_car, r_up, r_dn, w_nf, r_dir);
    assign w_arr_ahead = calls_ahead(w_pend, w_nf, r_dir);
    assign w_hit       = interior_movement[r_floor] | w_up_in[r_floor] | w_dn_in[r_floor];
    assign w_maint_req = r_maint_req | ((BCD_management == MAINT_CODE) && (r_state != S_MAINT));
    assign w_resume    = BCD_management == RESUME_CODE;

    assign engine  = r_engine;
    assign doors   = r_doors;
    assign floor   = r_floor;
    assign dir_up  = r_dir;
    assign maint   = r_state == S_MAINT;
    assign pending = w_pend;

    // Next-state, counters, call-register updates and maintenance request
    always_comb begin
        w_state_nx = r_state;
        w_floor_nx = r_floor;
        w_dir_nx   = r_dir;
        w_tcnt_nx  = r_tcnt;
        w_dcnt_nx  = r_dcnt;
        w_open     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_maint_req) w_state_nx = S_MAINT;
                else if (w_here) begin
                    w_state_nx = S_DOOR;
                    w_open     = 1'b1;
                    w_dcnt_nx  = '0;
                end else if (w_ahead || w_behind) begin
                    w_state_nx = S_MOVE;
                    w_dir_nx   = w_ahead ? r_dir : ~r_dir;
                    w_tcnt_nx  = '0;
                end
            end
            S_MOVE: begin
                if (r_tcnt == 16'(TRAVEL_CYCLES - 1)) begin
                    w_floor_nx = w_nf;
                    w_tcnt_nx  = '0;
                    if (w_maint_req) w_state_nx = S_MAINT;
                    else if (w_arr_stop) begin
                        w_state_nx = S_DOOR;
                        w_open     = 1'b1;
                        w_dcnt_nx  = '0;
                    end else if (!w_arr_ahead) w_state_nx = S_IDLE;
                end else w_tcnt_nx = r_tcnt + 16'd1;
            end
            S_DOOR: begin
                if (r_dcnt == 16'(DOOR_CYCLES - 1) && w_maint_req) w_state_nx = S_MAINT;
                else if (w_hit) w_dcnt_nx = '0;
                else if (r_dcnt == 16'(DOOR_CYCLES - 1)) w_state_nx = S_IDLE;
                else w_dcnt_nx = r_dcnt + 16'd1;
            end
            default: if (w_resume) w_state_nx = S_IDLE;
        endcase
        w_rev          = ~calls_ahead(w_pend, w_floor_nx, w_dir_nx);
        w_oh           = ONE << w_floor_nx;
        w_clr_car      = w_open ? w_oh : '0;
        w_clr_up       = (w_open && (w_dir_nx || w_rev)) ? w_oh : '0;
        w_clr_dn       = (w_open && (!w_dir_nx || w_rev)) ? w_oh : '0;
        w_block        = (r_state == S_DOOR) ? (ONE << r_floor) : '0;
        w_wipe         = (r_state == S_MAINT) || (w_state_nx == S_MAINT);
        w_car_nx       = w_wipe ? '0 : (r_car & ~w_clr_car) | (interior_movement & ~w_block);
        w_up_nx        = w_wipe ? '0 : (r_up & ~w_clr_up) | (w_up_in & ~w_block);
        w_dn_nx        = w_wipe ? '0 : (r_dn & ~w_clr_dn) | (w_dn_in & ~w_block);
        w_maint_req_nx = w_wipe ? 1'b0 : w_maint_req;
    end

    // State and registered actuator outputs, synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state     <= S_IDLE;
            r_floor     <= '0;
            r_dir       <= 1'b1;
            r_tcnt      <= '0;
            r_dcnt      <= '0;
            r_car       <= '0;
            r_up        <= '0;
            r_dn        <= '0;
            r_maint_req <= 1'b0;
            r_engine    <= 2'b00;
            r_doors     <= '0;
        end else begin
            r_state     <= w_state_nx;
            r_floor     <= w_floor_nx;
            r_dir       <= w_dir_nx;
            r_tcnt      <= w_tcnt_nx;
            r_dcnt      <= w_dcnt_nx;
            r_car       <= w_car_nx;
            r_up        <= w_up_nx;
            r_dn        <= w_dn_nx;
            r_maint_req <= w_maint_req_nx;
            r_engine    <= (w_state_nx == S_MOVE) ? (w_dir_nx ? 2'b01 : 2'b10) : 2'b00;
            r_doors     <= (w_state_nx == S_DOOR || w_state_nx == S_MAINT) ? w_oh : '0;
        end
    end
endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// tb_elevator_scan_ctrl: directed scoreboard bench for the SCAN elevator controller
module tb_elevator_scan_ctrl;
    localparam int FLOORS = 8;

    logic              CLK = 1'b0;
    logic              RST_N = 1'b0;
    logic [3:0]        BCD_management = 4'h0;
    logic [FLOORS-1:0] interior_movement = '0;
    logic [FLOORS-1:0] exterior_up = '0;
    logic [FLOORS-1:0] exterior_down = '0;
    logic [1:0]        engine;
    logic [FLOORS-1:0] doors;
    logic [2:0]        floor;
    logic              dir_up;
    logic              maint;
    logic [FLOORS-1:0] pending;

    elevator_scan_ctrl dut (
        .CLK(CLK), .RST_N(RST_N), .BCD_management(BCD_management),
        .interior_movement(interior_movement), .exterior_up(exterior_up),
        .exterior_down(exterior_down), .engine(engine), .doors(doors), .floor(floor),
        .dir_up(dir_up), .maint(maint), .pending(pending)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string       tag;
        int          sig;
        logic [15:0] exp;
    } exp_t;

    localparam int SIG_FLOOR = 0, SIG_ENGINE = 1, SIG_DOORS = 2, SIG_DIR = 3, SIG_MAINT = 4, SIG_PEND = 5;

    exp_t sb[$];
    int   stops[$];
    int   n_assert = 0;
    int   n_fail = 0;

    function automatic logic [15:0] obs(input int s);
        case (s)
            SIG_FLOOR:  return 16'(floor);
            SIG_ENGINE: return 16'(engine);
            SIG_DOORS:  return 16'(doors);
            SIG_DIR:    return 16'(dir_up);
            SIG_MAINT:  return 16'(maint);
            default:    return 16'(pending);
        endcase
    endfunction

    task automatic push(input string tag, input int sig, input logic [15:0] e);
        sb.push_back('{tag, sig, e});
    endtask

    task automatic drain();
        while (sb.size() > 0) begin
            exp_t        e;
            logic [15:0] o;
            e = sb.pop_front();
            o = obs(e.sig);
            n_assert++;
            assert (o === e.exp) else begin
                n_fail++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, o, e.exp);
            end
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic reset_dut();
        RST_N = 1'b0;
        tick(2);
        RST_N = 1'b1;
    endtask

    task automatic wait_doors(input string tag, input bit want_open, input int max);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < max && !ok; i++) begin
            tick();
            n_assert++;
            assert (!(engine != 2'b00 && doors != '0)) else begin
                n_fail++;
                $error("FAIL %s_invariant engine=%0h doors=%0h", tag, engine, doors);
            end
            ok = ((doors != '0) == want_open);
        end
        n_assert++;
        assert (ok) else begin
            n_fail++;
            $error("FAIL %s_timeout observed_doors=%0h expected_open=%0d", tag, doors, want_open);
        end
    endtask

    initial begin
        // 1: reset dominates active inputs
        interior_movement = 8'hFF;
        BCD_management = 4'b1011;
        tick(2);
        interior_movement = '0;
        BCD_management = 4'h0;
        push("rst_floor", SIG_FLOOR, 0); push("rst_engine", SIG_ENGINE, 0);
        push("rst_doors", SIG_DOORS, 0); push("rst_dir", SIG_DIR, 1);
        push("rst_maint", SIG_MAINT, 0); push("rst_pending", SIG_PEND, 0);
        drain();
        RST_N = 1'b1;

        // 2: single car call to floor 2
        interior_movement = 8'h04;
        tick();
        interior_movement = '0;
        push("sc_e0_pending", SIG_PEND, 16'h04); push("sc_e0_engine", SIG_ENGINE, 0);
        drain();
        tick();
        push("sc_e1_engine", SIG_ENGINE, 1); push("sc_e1_floor", SIG_FLOOR, 0);
        drain();
        tick(3);
        push("sc_e4_floor", SIG_FLOOR, 0);
        drain();
        tick();
        push("sc_e5_floor", SIG_FLOOR, 1); push("sc_e5_engine", SIG_ENGINE, 1);
        drain();
        tick(4);
        push("sc_e9_floor", SIG_FLOOR, 2); push("sc_e9_doors", SIG_DOORS, 16'h04);
        push("sc_e9_engine", SIG_ENGINE, 0); push("sc_e9_pending", SIG_PEND, 0);
        drain();
        tick(2);
        push("sc_e11_doors", SIG_DOORS, 16'h04);
        drain();
        tick();
        push("sc_e12_doors", SIG_DOORS, 0); push("sc_e12_engine", SIG_ENGINE, 0);
        push("sc_e12_pending", SIG_PEND, 0);
        drain();

        // 3: SCAN order from floor 0
        reset_dut();
        interior_movement = 8'h20;
        exterior_down = 8'h08;
        exterior_up = 8'h04;
        stops.push_back(2); stops.push_back(5); stops.push_back(3);
        tick();
        interior_movement = '0;
        exterior_down = '0;
        exterior_up = '0;
        push("scan_pending", SIG_PEND, 16'h2C);
        drain();
        while (stops.size() > 0) begin
            int f;
            f = stops.pop_front();
            wait_doors("scan_open", 1'b1, 200);
            push("scan_stop_floor", SIG_FLOOR, 16'(f));
            push("scan_stop_doors", SIG_DOORS, 16'(1 << f));
            push("scan_stop_dir", SIG_DIR, (f == 3) ? 16'd0 : 16'd1);
            drain();
            wait_doors("scan_close", 1'b0, 20);
        end
        push("scan_done_pending", SIG_PEND, 0);
        drain();

        // 4: door hold by re-pressing the current floor
        reset_dut();
        interior_movement = 8'h04;
        tick();
        interior_movement = '0;
        wait_doors("hold_open", 1'b1, 50);
        tick(2);
        push("hold_cnt2_doors", SIG_DOORS, 16'h04);
        drain();
        interior_movement = 8'h04;
        tick();
        interior_movement = '0;
        push("hold_restart_doors", SIG_DOORS, 16'h04); push("hold_not_latched", SIG_PEND, 0);
        drain();
        tick(2);
        push("hold_plus2_doors", SIG_DOORS, 16'h04);
        drain();
        tick();
        push("hold_plus3_doors", SIG_DOORS, 0);
        drain();

        // 5: maintenance mid-move, resume, then reset out of maintenance
        reset_dut();
        interior_movement = 8'h10;
        tick();
        interior_movement = '0;
        tick();
        BCD_management = 4'b1011;
        tick();
        BCD_management = 4'h0;
        push("mt_req_maint", SIG_MAINT, 0); push("mt_req_engine", SIG_ENGINE, 1);
        drain();
        tick(2);
        push("mt_e4_floor", SIG_FLOOR, 0);
        drain();
        tick();
        push("mt_floor", SIG_FLOOR, 1); push("mt_maint", SIG_MAINT, 1);
        push("mt_doors", SIG_DOORS, 16'h02); push("mt_engine", SIG_ENGINE, 0);
        push("mt_pending", SIG_PEND, 0);
        drain();
        interior_movement = 8'h40;
        exterior_up = 8'h01;
        BCD_management = 4'b1011;
        tick();
        interior_movement = '0;
        exterior_up = '0;
        BCD_management = 4'h0;
        push("mt_ignore_pending", SIG_PEND, 0); push("mt_still_maint", SIG_MAINT, 1);
        drain();
        BCD_management = 4'b1101;
        tick();
        BCD_management = 4'h0;
        push("mt_resume_maint", SIG_MAINT, 0); push("mt_resume_doors", SIG_DOORS, 0);
        push("mt_resume_engine", SIG_ENGINE, 0);
        drain();
        tick();
        push("mt_idle_engine", SIG_ENGINE, 0); push("mt_idle_floor", SIG_FLOOR, 1);
        drain();
        BCD_management = 4'b1011;
        tick();
        BCD_management = 4'h0;
        push("mt_idle_enter", SIG_MAINT, 1); push("mt_idle_doors", SIG_DOORS, 16'h02);
        drain();
        reset_dut();
        push("mt_rst_floor", SIG_FLOOR, 0); push("mt_rst_maint", SIG_MAINT, 0);
        push("mt_rst_doors", SIG_DOORS, 0); push("mt_rst_dir", SIG_DIR, 1);
        drain();

        // 6: masked hall bits, unknown and out-of-context codes
        exterior_up = 8'h80;
        exterior_down = 8'h01;
        BCD_management = 4'b0000;
        tick();
        exterior_up = '0;
        exterior_down = '0;
        push("edge_masked_pending", SIG_PEND, 0);
        drain();
        BCD_management = 4'b1101;
        tick();
        BCD_management = 4'b1111;
        tick();
        BCD_management = 4'h0;
        tick();
        push("edge_code_maint", SIG_MAINT, 0); push("edge_code_engine", SIG_ENGINE, 0);
        push("edge_code_doors", SIG_DOORS, 0);
        drain();
        exterior_up = 8'h01;
        tick();
        exterior_up = '0;
        push("edge_up0_pending", SIG_PEND, 16'h01);
        drain();
        tick();
        push("edge_up0_doors", SIG_DOORS, 16'h01); push("edge_up0_engine", SIG_ENGINE, 0);
        push("edge_up0_cleared", SIG_PEND, 0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
